// File: rtl/simd_mem_pkg.sv
// Shared types and constants for the SIMD cluster memory arbiter.
//   DATA_W      : RAM data width (one 64-bit word per access)
//   TOHOST_ADDR : byte address of the host-mailbox word
//   mem_cmd_t   : one RAM command as selected from the winning requester
//   lock_st_e   : burst-lock FSM states
//   rr_pick     : reference round-robin pick (first set bit at or after ptr, with wrap)
package simd_mem_pkg;

  localparam int unsigned DATA_W      = 64;
  localparam logic [63:0] TOHOST_ADDR = 64'h1000;

  typedef struct packed {
    logic              we;
    logic [63:0]       addr;   // byte address, zero-extended from the requester width
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wmask;
  } mem_cmd_t;

  typedef enum logic [0:0] {
    StUnlocked,
    StLocked
  } lock_st_e;

  // Scan-style round-robin pick for up to 8 requesters; n is the live requester count.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [7:0]  g;
    logic        found;
    int unsigned idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !found && req[idx[2:0]]) begin
        g[idx[2:0]] = 1'b1;
        found       = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/simd_rr_picker.sv
// Combinational round-robin picker: rotates the request vector so that position ptr
// becomes bit 0, isolates the lowest set bit, and rotates the one-hot result back.
// Ports:
//   req : request vector, one bit per requester
//   ptr : requester with highest priority this cycle (must be < N)
//   gnt : one-hot grant, all zero when req is zero
module simd_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [N-1:0] rot;
  logic [N-1:0] first;

  always_comb begin
    // Rotate right by ptr: rot[k] = req[(ptr + k) mod N].
    rot   = N'({req, req} >> ptr);
    // Two's-complement trick keeps only the lowest set bit.
    first = rot & (~rot + N'(1));
    // Rotate left by ptr, expressed as a right shift of the doubled vector.
    gnt   = N'({first, first} >> (N - 32'(ptr)));
  end

endmodule

// File: rtl/simd_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit synchronous RAM between NUM_REQ
// requesters, with short-burst locking, byte write masks and fixed-latency read return.
// Optional feature: define SIMD_MEM_ARB_TOHOST_EN to add a sticky host-mailbox capture
// (TOHOST_VALID / TOHOST_DATA) for writes to the word at TOHOST_ADDR.
// Ports:
//   CLK, RESET_N        : clock, synchronous active-low reset
//   REQ, LOCK, WE       : per-requester request, burst-lock request, write select
//   ADDR, WDATA, WMASK  : per-requester byte address, write data, byte enables (packed)
//   GNT                 : one-hot combinational grant
//   RVALID, RDATA       : one-hot read-return valid, broadcast read data
//   MEM_*               : RAM command side; MEM_RDATA returns MEM_LAT cycles after a read
//   TOHOST_VALID/DATA   : mailbox capture (only with SIMD_MEM_ARB_TOHOST_EN)
module simd_mem_arbiter
  import simd_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned AW       = 17,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic [NUM_REQ-1:0]          REQ,
  input  logic [NUM_REQ-1:0]          LOCK,
  input  logic [NUM_REQ-1:0]          WE,
  input  logic [NUM_REQ*AW-1:0]       ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]   WDATA,
  input  logic [NUM_REQ*8-1:0]        WMASK,
  output logic [NUM_REQ-1:0]          GNT,
  output logic [NUM_REQ-1:0]          RVALID,
  output logic [DATA_W-1:0]           RDATA,
  output logic                        MEM_EN,
  output logic                        MEM_WE,
  output logic [AW-4:0]               MEM_ADDR,
  output logic [DATA_W-1:0]           MEM_WDATA,
  output logic [7:0]                  MEM_WMASK,
  input  logic [DATA_W-1:0]           MEM_RDATA
`ifdef SIMD_MEM_ARB_TOHOST_EN
  ,
  output logic                        TOHOST_VALID,
  output logic [DATA_W-1:0]           TOHOST_DATA
`endif
);

  localparam int unsigned IdW     = $clog2(NUM_REQ);
  localparam int unsigned CntW    = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0] LockMax = CntW'(MAX_LOCK);
  localparam logic [IdW-1:0]  LastId  = IdW'(NUM_REQ - 1);

  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  lock_st_e           lock_st_q, lock_st_d;
  logic [IdW-1:0]     lock_owner_q, lock_owner_d;
  logic [CntW-1:0]    lock_cnt_q, lock_cnt_d;

  logic [NUM_REQ-1:0] gnt_rr;
  logic [NUM_REQ-1:0] gnt_raw;
  logic               lock_hold;
  logic [IdW-1:0]     win_idx;
  logic               any_gnt;
  mem_cmd_t           cmd;

  simd_rr_picker #(
    .N  (NUM_REQ),
    .PW (IdW)
  ) u_picker (
    .req (REQ),
    .ptr (rr_ptr_q),
    .gnt (gnt_rr)
  );

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  // A lock whose count has reached MAX_LOCK is not honoured: that cycle goes to
  // plain round-robin, which is what guarantees the forced release gap.
  assign lock_hold = (lock_st_q == StLocked) && (lock_cnt_q != LockMax) && REQ[lock_owner_q];

  always_comb begin
    gnt_raw = gnt_rr;
    if (lock_hold) begin
      gnt_raw               = '0;
      gnt_raw[lock_owner_q] = 1'b1;
    end
    GNT = RESET_N ? gnt_raw : '0;
  end

  assign any_gnt = |GNT;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) win_idx = IdW'(i);
    end
  end

  // One-hot AND-OR mux of the winner's fields; all zero when nothing is granted.
  always_comb begin
    cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GNT[i]) begin
        cmd.we    = WE[i];
        cmd.addr  = 64'(ADDR[i*AW +: AW]);
        cmd.wdata = WDATA[i*DATA_W +: DATA_W];
        cmd.wmask = WMASK[i*8 +: 8];
      end
    end
  end

  assign MEM_EN    = any_gnt;
  assign MEM_WE    = cmd.we;
  assign MEM_ADDR  = cmd.addr[AW-1:3];
  assign MEM_WDATA = cmd.wdata;
  assign MEM_WMASK = cmd.we ? cmd.wmask : 8'h00;

  // Byte offset and zero-extension bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmd.addr[63:AW], cmd.addr[2:0]};

  // ---------------------------------------------------------------------------
  // Round-robin pointer and lock FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = (win_idx == LastId) ? '0 : win_idx + IdW'(1);
    end
  end

  always_comb begin
    lock_st_d    = lock_st_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    unique case (lock_st_q)
      StUnlocked: begin
        if (any_gnt && LOCK[win_idx]) begin
          lock_st_d    = StLocked;
          lock_owner_d = win_idx;
          lock_cnt_d   = CntW'(1);
        end
      end
      StLocked: begin
        if (!lock_hold) begin
          // Owner dropped its request or exhausted its burst.
          lock_st_d  = StUnlocked;
          lock_cnt_d = '0;
        end else if (LOCK[lock_owner_q]) begin
          lock_cnt_d = lock_cnt_q + CntW'(1);
        end else begin
          lock_st_d  = StUnlocked;
          lock_cnt_d = '0;
        end
      end
      default: begin
        lock_st_d  = StUnlocked;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rr_ptr_q     <= '0;
      lock_st_q    <= StUnlocked;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_st_q    <= lock_st_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return pipeline: {valid, id} delayed MEM_LAT cycles
  // ---------------------------------------------------------------------------
  logic [MEM_LAT-1:0]          pipe_vld_q;
  logic [MEM_LAT-1:0][IdW-1:0] pipe_id_q;
  logic                        rd_issue;

  assign rd_issue = any_gnt & ~cmd.we;

  if (MEM_LAT > 1) begin : g_pipe_deep
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        pipe_vld_q <= '0;
        pipe_id_q  <= '0;
      end else begin
        pipe_vld_q <= {pipe_vld_q[MEM_LAT-2:0], rd_issue};
        pipe_id_q  <= {pipe_id_q[MEM_LAT-2:0], win_idx};
      end
    end
  end else begin : g_pipe_single
    always_ff @(posedge CLK) begin
      if (!RESET_N) begin
        pipe_vld_q <= '0;
        pipe_id_q  <= '0;
      end else begin
        pipe_vld_q <= rd_issue;
        pipe_id_q  <= win_idx;
      end
    end
  end

  // Gated by RESET_N so a read caught by reset never shows up, even with MEM_LAT=1.
  always_comb begin
    RVALID = '0;
    if (RESET_N && pipe_vld_q[MEM_LAT-1]) begin
      RVALID[pipe_id_q[MEM_LAT-1]] = 1'b1;
    end
  end

  assign RDATA = MEM_RDATA;

`ifdef SIMD_MEM_ARB_TOHOST_EN
  // ---------------------------------------------------------------------------
  // Host mailbox: sticky capture of masked bytes written to the TOHOST word
  // ---------------------------------------------------------------------------
  localparam logic [AW-4:0] TohostWord = TOHOST_ADDR[AW-1:3];

  logic              tohost_valid_q;
  logic [DATA_W-1:0] tohost_data_q;
  logic              tohost_hit;

  assign tohost_hit = any_gnt && cmd.we && (cmd.addr[AW-1:3] == TohostWord);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else if (tohost_hit) begin
      tohost_valid_q <= 1'b1;
      for (int b = 0; b < 8; b++) begin
        if (cmd.wmask[b]) tohost_data_q[b*8 +: 8] <= cmd.wdata[b*8 +: 8];
      end
    end
  end

  assign TOHOST_VALID = tohost_valid_q;
  assign TOHOST_DATA  = tohost_data_q;
`endif

endmodule

// File: tb/tb_simd_mem_arbiter.sv
module tb_simd_mem_arbiter;

  logic         CLK;
  logic         RESET_N;
  logic [3:0]   REQ, LOCK, WE;
  logic [67:0]  ADDR;
  logic [255:0] WDATA;
  logic [31:0]  WMASK;

  // DUT with MEM_LAT=1, backed by a RAM model
  logic [3:0]  GNT, RVALID;
  logic [63:0] RDATA, MEM_WDATA, MEM_RDATA;
  logic        MEM_EN, MEM_WE;
  logic [13:0] MEM_ADDR;
  logic [7:0]  MEM_WMASK;

  // DUT with MEM_LAT=2, only its grant/return timing is observed
  logic [3:0]  GNT_2, RVALID_2;
  logic [63:0] RDATA_2, MEM_WDATA_2, MEM_RDATA_2;
  logic        MEM_EN_2, MEM_WE_2;
  logic [13:0] MEM_ADDR_2;
  logic [7:0]  MEM_WMASK_2;

`ifdef SIMD_MEM_ARB_TOHOST_EN
  logic        TOHOST_VALID, TOHOST_VALID_2;
  logic [63:0] TOHOST_DATA, TOHOST_DATA_2;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  simd_mem_arbiter #(.NUM_REQ(4), .AW(17), .MEM_LAT(1), .MAX_LOCK(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .LOCK(LOCK), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .WMASK(WMASK), .GNT(GNT), .RVALID(RVALID), .RDATA(RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_WMASK(MEM_WMASK), .MEM_RDATA(MEM_RDATA)
`ifdef SIMD_MEM_ARB_TOHOST_EN
    , .TOHOST_VALID(TOHOST_VALID), .TOHOST_DATA(TOHOST_DATA)
`endif
  );

  simd_mem_arbiter #(.NUM_REQ(4), .AW(17), .MEM_LAT(2), .MAX_LOCK(4)) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(REQ), .LOCK(LOCK), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .WMASK(WMASK), .GNT(GNT_2), .RVALID(RVALID_2), .RDATA(RDATA_2),
    .MEM_EN(MEM_EN_2), .MEM_WE(MEM_WE_2), .MEM_ADDR(MEM_ADDR_2), .MEM_WDATA(MEM_WDATA_2),
    .MEM_WMASK(MEM_WMASK_2), .MEM_RDATA(MEM_RDATA_2)
`ifdef SIMD_MEM_ARB_TOHOST_EN
    , .TOHOST_VALID(TOHOST_VALID_2), .TOHOST_DATA(TOHOST_DATA_2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write-first single-port RAM model, 256 words, latency 1
  logic [63:0] ram [0:255];
  logic [63:0] ram_rdata;
  logic        ram_clr;

  always @(posedge CLK) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 64'h0;
      ram_rdata <= 64'h0;
    end else if (MEM_EN) begin
      if (MEM_WE) begin
        for (int b = 0; b < 8; b++)
          if (MEM_WMASK[b]) ram[MEM_ADDR[7:0]][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
      end else begin
        ram_rdata <= ram[MEM_ADDR[7:0]];
      end
    end
  end

  assign MEM_RDATA   = ram_rdata;
  assign MEM_RDATA_2 = 64'h0;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic clear_reqs();
    REQ = '0; LOCK = '0; WE = '0; ADDR = '0; WDATA = '0; WMASK = '0;
  endtask

  task automatic drive(input int i, input logic we, input logic lk, input logic [16:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    REQ[i] = 1'b1; WE[i] = we; LOCK[i] = lk;
    ADDR[i*17 +: 17] = a; WDATA[i*64 +: 64] = d; WMASK[i*8 +: 8] = m;
  endtask

  task automatic do_reset();
    clear_reqs();
    RESET_N = 1'b0;
    next_cycle();
    next_cycle();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ram_clr = 1'b1;
    clear_reqs();
    REQ = 4'hF; WE = 4'hF; WMASK = 32'hFFFF_FFFF; WDATA = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    next_cycle();
    next_cycle();
    settle();
    n_checks++; if (GNT !== 4'b0000) $display("FAIL rst_gnt: got %b required 0000", GNT); else n_pass++;
    n_checks++; if (MEM_EN !== 1'b0 || MEM_WE !== 1'b0)
      $display("FAIL rst_mem_en_we: got %b%b required 00", MEM_EN, MEM_WE); else n_pass++;
    n_checks++; if (MEM_WMASK !== 8'h00 || MEM_WDATA !== 64'h0)
      $display("FAIL rst_mem_data: got %h/%h required 00/0", MEM_WMASK, MEM_WDATA); else n_pass++;
    next_cycle();
    RESET_N = 1'b1; ram_clr = 1'b0;
    clear_reqs();
    settle();
    n_checks++; if (RVALID !== 4'b0000 || RVALID_2 !== 4'b0000)
      $display("FAIL rst_rvalid: got %b/%b required 0000", RVALID, RVALID_2); else n_pass++;
  endtask

  task automatic test_single_read();
    // Preload word 8 through requester 3, then requester 0 reads it back.
    drive(3, 1'b1, 1'b0, 17'h40, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    settle();
    n_checks++; if (GNT !== 4'b1000 || MEM_WE !== 1'b1 || MEM_WMASK !== 8'hFF)
      $display("FAIL sr_preload: got gnt=%b we=%b mask=%h required 1000/1/ff", GNT, MEM_WE, MEM_WMASK);
    else n_pass++;
    next_cycle();
    clear_reqs();
    drive(0, 1'b0, 1'b0, 17'h40, 64'h0, 8'h00);
    settle();
    n_checks++; if (GNT !== 4'b0001 || MEM_ADDR !== 14'd8 || MEM_EN !== 1'b1)
      $display("FAIL sr_grant: got gnt=%b addr=%0d en=%b required 0001/8/1", GNT, MEM_ADDR, MEM_EN);
    else n_pass++;
    n_checks++; if (MEM_WE !== 1'b0 || MEM_WMASK !== 8'h00 || RVALID !== 4'b0000)
      $display("FAIL sr_cmd: got we=%b mask=%h rvalid=%b required 0/00/0000", MEM_WE, MEM_WMASK, RVALID);
    else n_pass++;
    next_cycle();
    clear_reqs();
    settle();
    n_checks++; if (RVALID !== 4'b0001 || RDATA !== 64'hDEAD_BEEF_0000_0001)
      $display("FAIL sr_return: got rvalid=%b rdata=%h required 0001/deadbeef00000001", RVALID, RDATA);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g, exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 17'(32'h100 + i * 8), 64'h0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      settle();
      exp_g = 4'(1 << (k % 4));
      n_checks++; if (GNT !== exp_g)
        $display("FAIL rr_gnt_%0d: got %b required %b", k, GNT, exp_g); else n_pass++;
      if (k > 0) begin
        exp_v = 4'(1 << ((k - 1) % 4));
        n_checks++; if (RVALID !== exp_v)
          $display("FAIL rr_rvalid_%0d: got %b required %b", k, RVALID, exp_v); else n_pass++;
      end
      next_cycle();
    end
    clear_reqs();
    settle();
    n_checks++; if (RVALID !== 4'b0001)
      $display("FAIL rr_rvalid_last: got %b required 0001", RVALID); else n_pass++;
    next_cycle();
  endtask

  task automatic test_lock_limit();
    int ids [10] = '{0, 0, 0, 0, 1, 2, 3, 0, 0, 1};
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b0, (i == 0), 17'(32'h200 + i * 8), 64'h0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) LOCK = 4'b0000;   // owner releases voluntarily on its next grant
      settle();
      exp_g = 4'(1 << ids[k]);
      n_checks++; if (GNT !== exp_g)
        $display("FAIL lock_gnt_%0d: got %b required %b", k, GNT, exp_g); else n_pass++;
      next_cycle();
    end
    clear_reqs();
  endtask

  task automatic test_byte_write();
    drive(2, 1'b1, 1'b0, 17'h80, 64'h1122_3344_5566_7788, 8'h0F);
    settle();
    n_checks++; if (GNT !== 4'b0100 || MEM_WMASK !== 8'h0F || MEM_ADDR !== 14'd16)
      $display("FAIL bw_cmd: got gnt=%b mask=%h addr=%0d required 0100/0f/16", GNT, MEM_WMASK, MEM_ADDR);
    else n_pass++;
    n_checks++; if (MEM_WDATA !== 64'h1122_3344_5566_7788 || MEM_WE !== 1'b1)
      $display("FAIL bw_data: got %h we=%b required 1122334455667788/1", MEM_WDATA, MEM_WE);
    else n_pass++;
    next_cycle();
    clear_reqs();
    // Unaligned byte offset must be ignored; mask on a read must not leak out.
    drive(2, 1'b0, 1'b0, 17'h85, 64'h0, 8'h0F);
    settle();
    n_checks++; if (MEM_ADDR !== 14'd16 || MEM_WMASK !== 8'h00 || RVALID !== 4'b0000)
      $display("FAIL bw_read_cmd: got addr=%0d mask=%h rvalid=%b required 16/00/0000",
               MEM_ADDR, MEM_WMASK, RVALID);
    else n_pass++;
    next_cycle();
    clear_reqs();
    settle();
    n_checks++; if (RVALID !== 4'b0100 || RDATA !== 64'h0000_0000_5566_7788)
      $display("FAIL bw_readback: got rvalid=%b rdata=%h required 0100/0000000055667788", RVALID, RDATA);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    clear_reqs();
    do_reset();
    drive(0, 1'b0, 1'b0, 17'h300, 64'h0, 8'h00);
    settle();
    n_checks++; if (GNT_2 !== 4'b0001)
      $display("FAIL mf_issue: got %b required 0001", GNT_2); else n_pass++;
    next_cycle();
    RESET_N = 1'b0;
    settle();
    n_checks++; if (GNT_2 !== 4'b0000 || MEM_EN_2 !== 1'b0 || RVALID_2 !== 4'b0000)
      $display("FAIL mf_in_reset: got gnt=%b en=%b rvalid=%b required 0000/0/0000",
               GNT_2, MEM_EN_2, RVALID_2);
    else n_pass++;
    next_cycle();
    RESET_N = 1'b1;
    clear_reqs();
    for (int k = 0; k < 2; k++) begin
      settle();
      n_checks++; if (RVALID_2 !== 4'b0000)
        $display("FAIL mf_no_return_%0d: got %b required 0000", k, RVALID_2); else n_pass++;
      next_cycle();
    end
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 1'b0, 17'h300, 64'h0, 8'h00);
    settle();
    n_checks++; if (GNT_2 !== 4'b0001 || GNT !== 4'b0001)
      $display("FAIL mf_ptr_zero: got %b/%b required 0001", GNT_2, GNT); else n_pass++;
    next_cycle();
    clear_reqs();
    next_cycle();
  endtask

`ifdef SIMD_MEM_ARB_TOHOST_EN
  task automatic test_tohost();
    do_reset();
    settle();
    n_checks++; if (TOHOST_VALID !== 1'b0)
      $display("FAIL th_reset: got %b required 0", TOHOST_VALID); else n_pass++;
    next_cycle();
    drive(1, 1'b1, 1'b0, 17'h1000, 64'h1, 8'hFF);
    settle();
    n_checks++; if (TOHOST_VALID !== 1'b0 || MEM_ADDR !== 14'h200 || MEM_EN !== 1'b1)
      $display("FAIL th_issue: got v=%b addr=%h en=%b required 0/200/1", TOHOST_VALID, MEM_ADDR, MEM_EN);
    else n_pass++;
    next_cycle();
    clear_reqs();
    settle();
    n_checks++; if (TOHOST_VALID !== 1'b1 || TOHOST_DATA !== 64'h1)
      $display("FAIL th_capture: got %b/%h required 1/0000000000000001", TOHOST_VALID, TOHOST_DATA);
    else n_pass++;
    next_cycle();
    drive(2, 1'b1, 1'b0, 17'h1000, 64'hFFFF_FFFF_FFFF_ABFF, 8'h02);
    next_cycle();
    clear_reqs();
    drive(0, 1'b1, 1'b0, 17'h1008, 64'h5555, 8'hFF);
    next_cycle();
    clear_reqs();
    settle();
    n_checks++; if (TOHOST_VALID !== 1'b1 || TOHOST_DATA !== 64'hAB01)
      $display("FAIL th_merge: got %b/%h required 1/000000000000ab01", TOHOST_VALID, TOHOST_DATA);
    else n_pass++;
    next_cycle();
  endtask
`endif

  initial begin
    ram_clr = 1'b1;
    RESET_N = 1'b0;
    clear_reqs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_limit();
    test_byte_write();
    test_reset_midflight();
`ifdef SIMD_MEM_ARB_TOHOST_EN
    test_tohost();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_mem_arbiter.md
Name: simd_mem_arbiter

Overview:
- Shares one single-port, 64-bit-wide synchronous RAM between NUM_REQ requesters, for example the I-fetch and D-access ports of one or more steel_core_top_64 lanes in the SIMD cluster.
- Uses round-robin arbitration with optional short-burst locking, per-byte write masks, and fixed-latency read-return routing.
- Sits between the cores' memory ports and the shared RAM macro in the SIMD core top.

Parameters:
- NUM_REQ, 4: number of requesters; must be 2..8.
- AW, 17: byte-address width seen by requesters.
- MEM_LAT, 1: RAM read latency in cycles; must be 1..3.
- MAX_LOCK, 4: maximum consecutive grants to one locked requester.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous active-low reset.
- REQ  in  NUM_REQ  request per requester; held until granted.
- LOCK  in  NUM_REQ  requester asks to keep priority after this grant.
- WE  in  NUM_REQ  1 = write, 0 = read.
- ADDR  in  NUM_REQ*AW  byte address per requester (slice i = requester i).
- WDATA  in  NUM_REQ*64  write data.
- WMASK  in  NUM_REQ*8  byte enables.
- GNT  out  NUM_REQ  one-hot grant, combinational, same cycle as REQ.
- RVALID  out  NUM_REQ  read-data valid, one-hot.
- RDATA  out  64  read data, broadcast; qualified by RVALID.
- MEM_EN  out  1  RAM enable.
- MEM_WE  out  1  RAM write enable.
- MEM_ADDR  out  AW-3  RAM word address, ADDR[AW-1:3] of the winner.
- MEM_WDATA  out  64  winner WDATA.
- MEM_WMASK  out  8  winner WMASK; forced 0 on reads.
- MEM_RDATA  in  64  RAM read data, valid MEM_LAT cycles after a read command.

Behaviour:
- Reset (RESET_N low at posedge):
  - rr_ptr=0, lock_owner cleared, lock_cnt=0, RVALID pipeline flushed.
  - All outputs 0: GNT and MEM_* are 0 while RESET_N is low; RVALID=0 for the cycle after reset.
- Reset mid-operation: any in-flight read is discarded and its RVALID is never asserted. Writes already issued to the RAM are not undone.
- Arbitration (combinational each cycle):
  - If lock_owner is valid and REQ[lock_owner]=1, it wins.
  - Otherwise the first set REQ bit scanning from rr_ptr upward, with wrap-around, wins.
  - No REQ set: GNT=0, MEM_EN=0.
- Memory command: winner's fields drive MEM_*; MEM_EN=1; MEM_WE=WE[w].
- Pointer update (at posedge, on a grant to w): rr_ptr <= (w+1) mod NUM_REQ. The pointer updates even while locked, so rotation resumes fairly after release.
- Lock FSM:
  - States UNLOCKED and LOCKED(owner, lock_cnt).
  - UNLOCKED -> LOCKED when granted w has LOCK[w]=1; lock_cnt <= 1.
  - LOCKED, grant to owner with LOCK=1 and lock_cnt<MAX_LOCK: stay LOCKED, lock_cnt++.
  - LOCKED -> UNLOCKED on any of: LOCK[owner]=0 at grant; REQ[owner]=0; or lock_cnt==MAX_LOCK, which forces release for at least one cycle.
- Fairness bound: an unlocked requester is granted within (NUM_REQ-1)*MAX_LOCK+1 cycles.
- Read return:
  - A MEM_LAT-deep shift register carries {valid, id}.
  - RVALID[id]=1 exactly MEM_LAT cycles after the grant cycle; RDATA=MEM_RDATA.
  - Back-to-back reads are fully pipelined, one per cycle.
  - Writes produce no RVALID.
- Same-cycle write followed by a read of the same word: the read returns the new data, because RAM write-first behaviour is required of the macro.
- ADDR[2:0] is ignored; alignment is the requester's job.

Optional Feature:
- Macro: SIMD_MEM_ARB_TOHOST_EN.
- Enabled:
  - Extra outputs TOHOST_VALID (1) and TOHOST_DATA (64).
  - Any granted write with ADDR word == 0x1000>>3 sets TOHOST_VALID sticky and latches the masked bytes of WDATA into TOHOST_DATA.
  - Both are cleared only by reset.
  - The write still goes to the RAM.
- Disabled: the ports are absent and there is no extra logic.

Decomposition:
- Package simd_mem_pkg:
  - localparams TOHOST_ADDR=64'h1000 and DATA_W=64.
  - typedef mem_cmd_t {we, addr, wdata, wmask}.
  - function rr_pick(req, ptr) returning a one-hot vector.
- One sub-module, simd_rr_picker: a combinational rotate/priority-encode/rotate-back producing the one-hot grant. The lock FSM and return pipeline stay in the top.

Test Plan:
- Single read: REQ=4'b0001, ADDR0=0x40, RAM word 8 = 0xDEAD_BEEF_0000_0001, MEM_LAT=1 -> GNT=0001 same cycle, MEM_ADDR=8; next cycle RVALID=0001, RDATA=0xDEADBEEF00000001.
- Round-robin: REQ=4'b1111 held with LOCK=0 -> grants 0,1,2,3,0 on consecutive cycles; rr_ptr wraps 3->0.
- Lock limit: REQ=1111, LOCK=0001, MAX_LOCK=4 -> requester 0 granted 4 consecutive cycles, then requester 1 is granted the 5th cycle.
- Byte write: requester 2 writes WDATA=0x1122334455667788, WMASK=8'h0F to ADDR 0x80 with prior word 0 -> MEM_WMASK=0F; readback returns 0x0000000055667788.
- Reset mid-flight: issue a read with MEM_LAT=2, drive RESET_N=0 on the next posedge -> RVALID never asserts; GNT=0 during reset; rr_ptr=0 afterwards.
- Tohost (SIMD_MEM_ARB_TOHOST_EN): write 0x1 with WMASK=FF to ADDR 0x1000 -> TOHOST_VALID=1 and TOHOST_DATA=0x0000000000000001 on the next cycle.
